// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default bus widths, reset PC and the fetch
// state encoding used by the fetch stage.
package cpu_pkg;

  localparam int          CPU_ADDR_W   = 32;
  localparam int          CPU_DATA_W   = 32;
  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, branch redirect
// and the decode-side instruction handshake.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two instruction FIFO with flush; the head entry is read
// straight out of the storage registers.
module fetch_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_s;

  assign pop_s = pop & ~empty;
  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit_checker.sv
// Invariant checks for the fetch stage: credits keep the FIFO from overflowing
// and the FSM state mirrors the discard counter.
module fetch_unit_checker
  import cpu_pkg::*;
#(
  parameter int CW = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          fifo_push,
  input logic          fifo_full,
  input fetch_state_e  state,
  input logic [CW-1:0] discard
);

  push_never_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full));

  state_tracks_discard: assert property (@(posedge clk) disable iff (!rst_n)
    ((state == FLUSH) == (discard != {CW{1'b0}})));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: word-addressed PC, credit-limited requests to a
// variable-latency memory, response buffering and branch-redirect flushing.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                DATA_W   = CPU_DATA_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                     active_r;
  logic [ADDR_W-1:0]        fetch_pc_r;
  logic [ADDR_W-1:0]        rsp_pc_r;
  logic [CW-1:0]            outstanding_r;
  logic [CW-1:0]            discard_r;
  fetch_state_e             state_r;
  logic [CW-1:0]            outstanding_nx_s;
  logic [CW-1:0]            discard_nx_s;
  logic [CW-1:0]            fifo_count_s;
  logic [CW-1:0]            occupancy_s;
  logic                     redirect_s;
  logic                     hs_s;
  logic                     rsp_s;
  logic                     drop_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic [ADDR_W+DATA_W-1:0] fifo_rdata_s;

  assign redirect_s = bus.redirect_valid;
  assign rsp_s      = bus.imem_rsp_valid;
  assign pop_s      = ~fifo_empty_s & bus.instr_ready & ~redirect_s;

  // A slot freed by this cycle's pop is immediately reusable, sustaining one word per cycle.
  assign occupancy_s        = outstanding_r + fifo_count_s - CW'(pop_s);
  assign bus.imem_req_valid = active_r & ~redirect_s & (occupancy_s < CW'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc_r;
  assign hs_s               = bus.imem_req_valid & bus.imem_req_ready;

  assign drop_s = rsp_s & (discard_r != {CW{1'b0}});
  assign push_s = rsp_s & ~drop_s & ~redirect_s;

  assign bus.instr_valid          = ~fifo_empty_s;
  assign {bus.instr_pc, bus.instr} = fifo_rdata_s;

  // Next outstanding and discard counts; a redirect must discard everything still in flight.
  always_comb begin
    outstanding_nx_s = outstanding_r;
    case ({hs_s, rsp_s})
      2'b10:   outstanding_nx_s = outstanding_r + CW'(1);
      2'b01:   outstanding_nx_s = outstanding_r - CW'(1);
      default: outstanding_nx_s = outstanding_r;
    endcase
    discard_nx_s = discard_r;
    if (redirect_s) begin
      discard_nx_s = outstanding_nx_s;
    end else if (drop_s) begin
      discard_nx_s = discard_r - CW'(1);
    end else begin
      discard_nx_s = discard_r;
    end
  end

  // PC, response-PC and credit counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r      <= 1'b0;
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      discard_r     <= {CW{1'b0}};
    end else begin
      active_r      <= 1'b1;
      outstanding_r <= outstanding_nx_s;
      discard_r     <= discard_nx_s;
      if (redirect_s) begin
        fetch_pc_r <= bus.redirect_pc;
        rsp_pc_r   <= bus.redirect_pc;
      end else begin
        if (hs_s)   fetch_pc_r <= fetch_pc_r + ADDR_W'(1);
        if (push_s) rsp_pc_r   <= rsp_pc_r + ADDR_W'(1);
      end
    end
  end

  // RUN/FLUSH state: FLUSH while stale responses remain to be dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      case (state_r)
        RUN:     state_r <= (discard_nx_s != {CW{1'b0}}) ? FLUSH : RUN;
        FLUSH:   state_r <= (discard_nx_s == {CW{1'b0}}) ? RUN : FLUSH;
        default: state_r <= RUN;
      endcase
    end
  end

  fetch_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_s),
    .wdata ({rsp_pc_r, bus.imem_rsp_data}),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  fetch_unit_checker #(
    .CW (CW)
  ) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_push (push_s),
    .fifo_full (fifo_full_s),
    .state     (state_r),
    .discard   (discard_r)
  );

endmodule
